sseg_mux_driver: RTL

SSEG_MUX_DRIVER -- requirements
Module: sseg_mux_driver

---
 rtl/sseg_mux_driver.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sseg_mux_driver.sv
// Time-multiplexed seven-segment display driver with frame-synchronous
// double buffering, hex/BCD decoding, leading-zero blanking and anti-ghosting.
module sseg_mux_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int ACTIVE_LOW_SEG = 1,
  parameter int ACTIVE_LOW_AN  = 1,
  parameter int HEX_MODE       = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic                    lzb_i,
  input  logic                    load_i,
  output logic [7:0]              sseg_o,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic                    frame_tick_o
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]             presc;
  logic [IW-1:0]             idx;
  logic [4*NUM_DIGITS-1:0]   disp_digits, pend_digits;
  logic [NUM_DIGITS-1:0]     disp_dp, pend_dp;
  logic [NUM_DIGITS-1:0]     disp_blank, pend_blank;
  logic                      pend_valid;

  logic                      presc_wrap, frame_wrap;
  logic [NUM_DIGITS-1:0]     lz_blank;
  logic                      zero_run;
  logic [3:0]                cur_nib;
  logic                      cur_dp, cur_blank, cur_lz;
  logic [NUM_DIGITS-1:0]     an_hot, an_act;
  logic [7:0]                seg_act;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    if (HEX_MODE == 0 && nib > 4'h9) g = 7'h00;
    return g;
  endfunction

  // Forced blank outranks everything, including the decimal point;
  // zero blanking only darkens a-g so dp stays available.
  function automatic logic [7:0] seg_byte(input logic [3:0] nib, input logic dp,
                                          input logic blank, input logic lz_off);
    logic [6:0] g;
    logic [7:0] b;
    g = lz_off ? 7'h00 : glyph(nib);
    b = {dp, g};
    if (blank) b = 8'h00;
    return b;
  endfunction

  function automatic logic [7:0] seg_pol(input logic [7:0] b);
    return (ACTIVE_LOW_SEG != 0) ? ~b : b;
  endfunction

  function automatic logic [NUM_DIGITS-1:0] an_pol(input logic [NUM_DIGITS-1:0] a);
    return (ACTIVE_LOW_AN != 0) ? ~a : a;
  endfunction

  assign presc_wrap = (presc == PRESC_LAST);
  assign frame_wrap = presc_wrap && (idx == IDX_LAST);

  // A digit is a leading zero when it and every more significant nibble is 0.
  always_comb begin
    zero_run = 1'b1;
    lz_blank = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (disp_digits[4*k +: 4] == 4'h0);
      if (k > 0) lz_blank[k] = zero_run;
    end
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_lz    = 1'b0;
    an_hot    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_nib   = disp_digits[4*k +: 4];
        cur_dp    = disp_dp[k];
        cur_blank = disp_blank[k];
        cur_lz    = lz_blank[k];
        an_hot[k] = 1'b1;
      end
    end
  end

  // Anodes go dark for the first cycle of each slot so segment changes never ghost.
  assign an_act  = (presc == '0) ? '0 : an_hot;
  assign seg_act = seg_byte(cur_nib, cur_dp, cur_blank, lzb_i & cur_lz);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc        <= '0;
      idx          <= '0;
      disp_digits  <= '0;
      disp_dp      <= '0;
      disp_blank   <= '0;
      pend_digits  <= '0;
      pend_dp      <= '0;
      pend_blank   <= '0;
      pend_valid   <= 1'b0;
      sseg_o       <= seg_pol(8'h00);
      anodes       <= an_pol('0);
      frame_tick_o <= 1'b0;
    end else begin
      presc <= presc_wrap ? '0 : presc + 1'b1;
      if (presc_wrap) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      frame_tick_o <= frame_wrap;

      // Display only swaps at the frame boundary; a coincident load bypasses pending.
      if (frame_wrap) begin
        if (load_i) begin
          disp_digits <= digits_i;
          disp_dp     <= dp_i;
          disp_blank  <= blank_i;
        end else if (pend_valid) begin
          disp_digits <= pend_digits;
          disp_dp     <= pend_dp;
          disp_blank  <= pend_blank;
        end
        pend_valid <= 1'b0;
      end else if (load_i) begin
        pend_digits <= digits_i;
        pend_dp     <= dp_i;
        pend_blank  <= blank_i;
        pend_valid  <= 1'b1;
      end

      sseg_o <= seg_pol(seg_act);
      anodes <= an_pol(an_act);
    end
  end

endmodule
